// File: rtl/clk_freq_meter.sv
// ---------------------------------------------------------------------------
// clk_freq_meter
//
// Gated edge counter: counts rising edges of an asynchronous input clock
// (meas_in) over a programmable window of gate_len system-clock cycles and
// reports the result as a one-cycle valid pulse with count_out / overflow.
//
// Parameters
//   GATE_W      width of gate_len and the gate down-counter
//   CNT_W       width of the edge counter and count_out
//   SYNC_STAGES synchronizer depth on meas_in (minimum 2)
//
// Ports
//   clk       in   system clock, all state on rising edge
//   reset     in   asynchronous active-high reset
//   meas_in   in   clock under measurement (asynchronous to clk)
//   start     in   one-cycle request to begin a measurement (ignored while busy)
//   abort     in   cancel measurement in progress (priority over start/done)
//   gate_len  in   window length in clk cycles, sampled on accepted start
//   count_out out  rising edges counted in last completed window
//   valid     out  one-cycle pulse when count_out/overflow update
//   busy      out  high while in MEASURE or DONE
//   overflow  out  last completed window saturated the edge counter
//
// Build option
//   CLK_FREQ_METER_CONTINUOUS_EN  when defined, DONE re-samples gate_len and
//   starts a new window immediately, repeating until abort. When undefined,
//   DONE returns to IDLE (single-shot).
// ---------------------------------------------------------------------------
module clk_freq_meter #(
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              meas_in,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CNT_W-1:0]  count_out,
    output logic              valid,
    output logic              busy,
    output logic              overflow
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   edge_det;
    logic [GATE_W-1:0]      gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   ovf_sticky;

    // Synchronizer chain plus one delay flop for the edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], meas_in};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_d;
    assign busy     = (state == S_MEASURE) || (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_sticky <= 1'b0;
            count_out  <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        gate_cnt   <= gate_len;
                        edge_cnt   <= '0;
                        ovf_sticky <= 1'b0;
                        // A zero-length window skips MEASURE and reports 0.
                        state      <= (gate_len == '0) ? S_DONE : S_MEASURE;
                    end
                end

                S_MEASURE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        gate_cnt <= gate_cnt - GATE_ONE;
                        if (gate_cnt == GATE_ONE)
                            state <= S_DONE;
                        // The final MEASURE cycle still counts its edge.
                        if (edge_det) begin
                            if (edge_cnt == CNT_MAX)
                                ovf_sticky <= 1'b1;
                            else
                                edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        count_out <= edge_cnt;
                        overflow  <= ovf_sticky;
                        valid     <= 1'b1;
`ifdef CLK_FREQ_METER_CONTINUOUS_EN
                        gate_cnt   <= gate_len;
                        edge_cnt   <= '0;
                        ovf_sticky <= 1'b0;
                        state      <= (gate_len == '0) ? S_DONE : S_MEASURE;
`else
                        state <= S_IDLE;
`endif
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_freq_meter.sv
module tb_clk_freq_meter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        meas8 = 1'b0;
    logic        meas2 = 1'b0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] gate_len = '0;

    logic [15:0] count_out;
    logic        valid, busy, overflow;
    logic [3:0]  s_count;
    logic        s_valid, s_busy, s_overflow;

    int checks = 0;
    int errors = 0;

    // Main meter: default widths, fed by a period-8 clock.
    clk_freq_meter #(.GATE_W(16), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .meas_in(meas8), .start(start), .abort(abort),
        .gate_len(gate_len), .count_out(count_out), .valid(valid), .busy(busy),
        .overflow(overflow)
    );

    // Narrow meter for saturation: 4-bit counter, period-2 clock.
    clk_freq_meter #(.GATE_W(16), .CNT_W(4), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .reset(reset), .meas_in(meas2), .start(start_s), .abort(abort),
        .gate_len(gate_len), .count_out(s_count), .valid(s_valid), .busy(s_busy),
        .overflow(s_overflow)
    );

    always #5 clk = ~clk;
    initial begin #3; forever #40 meas8 = ~meas8; end
    initial begin #7; forever #10 meas2 = ~meas2; end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one sampled edge, then count edges until valid.
    task automatic run_window(input logic [15:0] gl, output int lat);
        gate_len = gl;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (valid) begin lat = i; break; end
        end
    endtask

    task automatic stop_dut;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        #1;
        checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL reset_s_count: got %0d expected 0", s_count); end
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int lat;
        run_window(16'd64, lat);
        checks++; if (lat !== 65) begin errors++; $display("FAIL basic_latency: got %0d expected 65", lat); end
        checks++; if (count_out !== 16'd8) begin errors++; $display("FAIL basic_count: got %0d expected 8", count_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", overflow); end
`ifndef CLK_FREQ_METER_CONTINUOUS_EN
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop: got %b expected 0", busy); end
`endif
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b expected 0", valid); end
        checks++; if (count_out !== 16'd8) begin errors++; $display("FAIL basic_hold: got %0d expected 8", count_out); end
        stop_dut();
    endtask

    task automatic test_zero_window;
        int lat;
        run_window(16'd0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
        checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", count_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zero_ovf: got %b expected 0", overflow); end
        stop_dut();
    endtask

    task automatic sat_window(input logic [15:0] gl, output int lat);
        gate_len = gl;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (s_valid) begin lat = i; break; end
        end
    endtask

    task automatic test_saturation;
        int lat;
        sat_window(16'd64, lat);
        checks++; if (lat !== 65) begin errors++; $display("FAIL sat_latency: got %0d expected 65", lat); end
        checks++; if (s_count !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d expected 15", s_count); end
        checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", s_overflow); end
        stop_dut();
        // Sticky flag must clear on the next accepted start.
        sat_window(16'd4, lat);
        checks++; if (s_count !== 4'd2) begin errors++; $display("FAIL sat_clear_count: got %0d expected 2", s_count); end
        checks++; if (s_overflow !== 1'b0) begin errors++; $display("FAIL sat_clear_ovf: got %b expected 0", s_overflow); end
        stop_dut();
    endtask

    task automatic test_back_to_back;
        int lat;
        gate_len = 16'd64;
        start = 1'b1;
        tick();
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            if (i == 10) begin start = 1'b1; gate_len = 16'd5; end
            else begin start = 1'b0; gate_len = 16'd64; end
            tick();
            if (valid) begin lat = i; break; end
        end
        start = 1'b0;
        checks++; if (lat !== 65) begin errors++; $display("FAIL b2b_latency: got %0d expected 65", lat); end
        checks++; if (count_out !== 16'd8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", count_out); end
        stop_dut();
    endtask

    task automatic test_abort;
        int seen;
        gate_len = 16'd64;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", valid); end
        checks++; if (count_out !== 16'd8) begin errors++; $display("FAIL abort_count_kept: got %0d expected 8", count_out); end
        seen = 0;
        repeat (80) begin tick(); if (valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_reset_mid;
        int lat;
        gate_len = 16'd64;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (count_out !== 16'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
        checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL rstmid_s_count: got %0d expected 0", s_count); end
        tick(); tick();
        reset = 1'b0;
        tick();
        run_window(16'd64, lat);
        checks++; if (lat !== 65) begin errors++; $display("FAIL rstmid_latency: got %0d expected 65", lat); end
        checks++; if (count_out !== 16'd8) begin errors++; $display("FAIL rstmid_count_after: got %0d expected 8", count_out); end
        stop_dut();
    endtask

`ifdef CLK_FREQ_METER_CONTINUOUS_EN
    task automatic test_continuous;
        int lat;
        int gap;
        run_window(16'd32, lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL cont_first_latency: got %0d expected 33", lat); end
        checks++; if (count_out !== 16'd4) begin errors++; $display("FAIL cont_first_count: got %0d expected 4", count_out); end
        for (int k = 0; k < 2; k++) begin
            gap = -1;
            for (int i = 1; i <= 200; i++) begin
                tick();
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy: got %b expected 1", busy); end
                if (valid) begin gap = i; break; end
            end
            checks++; if (gap !== 33) begin errors++; $display("FAIL cont_period: got %0d expected 33", gap); end
            checks++; if (count_out !== 16'd4) begin errors++; $display("FAIL cont_count: got %0d expected 4", count_out); end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_abort_busy: got %b expected 0", busy); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_window();
        test_saturation();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef CLK_FREQ_METER_CONTINUOUS_EN
        test_continuous();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
